// File: rtl/stereo_pdm_deserializer.sv
// Stereo PDM microphone deserializer: divides clock_i into pdm_clk_o, captures
// the left channel on pdm_clk_o rising edges and the right channel on falling
// edges, packs WORD_LENGTH bits per word (MSB first) and queues {channel, word}
// in a small FIFO drained by a valid/ready sink.
//
// Ports:
//   clock_i      system clock, rising edge
//   reset_i      asynchronous active-high reset
//   enable_i     capture enable; low clears divider, bit counter, shifters
//   pdm_clk_o    microphone clock, SYSTEM_FREQUENCY/(2*HALF)
//   pdm_data_i   shared PDM data line
//   pdm_lrsel_o  microphone L/R select, tied low
//   data_o       FIFO head word (0 when empty)
//   channel_o    FIFO head channel, 0 = left, 1 = right (0 when empty)
//   valid_o      FIFO not empty
//   ready_i      sink accepts head word this edge
//   overrun_o    sticky: a word was dropped on a full FIFO
module stereo_pdm_deserializer #(
   parameter int WORD_LENGTH        = 16,
   parameter int SYSTEM_FREQUENCY   = 100000000,
   parameter int SAMPLING_FREQUENCY = 1000000,
   parameter int STEREO             = 1,
   parameter int FIFO_DEPTH         = 4
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   input  logic                   enable_i,
   output logic                   pdm_clk_o,
   input  logic                   pdm_data_i,
   output logic                   pdm_lrsel_o,
   output logic [WORD_LENGTH-1:0] data_o,
   output logic                   channel_o,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic                   overrun_o
);

   localparam int  HALF      = SYSTEM_FREQUENCY / (2 * SAMPLING_FREQUENCY);
   localparam int  DW        = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int  BW        = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
   localparam int  PW        = $clog2(FIFO_DEPTH);
   localparam int  CW        = PW + 1;
   localparam bit  IS_STEREO = (STEREO != 0);

   logic [DW-1:0]          div_cnt;
   logic [BW-1:0]          bit_cnt;
   logic [WORD_LENGTH-1:0] left_sr;
   logic [WORD_LENGTH-1:0] right_sr;
   logic [WORD_LENGTH-1:0] left_next;
   logic [WORD_LENGTH-1:0] right_next;
   logic                   tick;
   logic                   rise;
   logic                   fall;
   logic                   word_end;

   logic [WORD_LENGTH:0]   mem [FIFO_DEPTH];
   logic [WORD_LENGTH:0]   head;
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [CW-1:0]          count;
   logic                   full;
   logic                   push;
   logic                   pop;
   logic                   accept;
   logic                   push_ch;
   logic [WORD_LENGTH-1:0] push_word;

   assign pdm_lrsel_o = 1'b0;

   // tick marks the edge that toggles pdm_clk_o; its direction selects the channel
   assign tick       = enable_i && (div_cnt == DW'(HALF - 1));
   assign rise       = tick && !pdm_clk_o;
   assign fall       = tick && pdm_clk_o;
   assign word_end   = (bit_cnt == BW'(WORD_LENGTH - 1));
   assign left_next  = {left_sr[WORD_LENGTH-2:0], pdm_data_i};
   assign right_next = {right_sr[WORD_LENGTH-2:0], pdm_data_i};

   // push carries the bit sampled on this very edge, so the word lands with no delay
   assign push      = word_end && (rise || (fall && IS_STEREO));
   assign push_ch   = fall;
   assign push_word = rise ? left_next : right_next;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         div_cnt   <= '0;
         pdm_clk_o <= 1'b0;
         bit_cnt   <= '0;
         left_sr   <= '0;
         right_sr  <= '0;
      end else if (!enable_i) begin
         div_cnt   <= '0;
         pdm_clk_o <= 1'b0;
         bit_cnt   <= '0;
         left_sr   <= '0;
         right_sr  <= '0;
      end else begin
         if (tick) begin
            div_cnt   <= '0;
            pdm_clk_o <= ~pdm_clk_o;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
         if (rise) begin
            left_sr <= left_next;
         end
         if (fall) begin
            if (IS_STEREO) begin
               right_sr <= right_next;
            end
            bit_cnt <= word_end ? '0 : bit_cnt + 1'b1;
         end
      end
   end

   assign valid_o = (count != '0);
   assign full    = (count == CW'(FIFO_DEPTH));
   assign pop     = valid_o && ready_i;
   // a pop on the same edge frees the slot, so a full FIFO still accepts
   assign accept  = push && (!full || pop);

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overrun_o <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (accept && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !accept) begin
            count <= count - 1'b1;
         end
         if (push && full && !pop) begin
            overrun_o <= 1'b1;
         end
      end
   end

   // storage needs no reset: the head is masked whenever the FIFO is empty
   always_ff @(posedge clock_i) begin
      if (accept) begin
         mem[wr_ptr] <= {push_ch, push_word};
      end
   end

   assign head      = mem[rd_ptr];
   assign data_o    = valid_o ? head[WORD_LENGTH-1:0] : '0;
   assign channel_o = valid_o && head[WORD_LENGTH];

endmodule

// File: tb/tb_stereo_pdm_deserializer.sv
// Testbench for stereo_pdm_deserializer: a mono and a stereo instance against
// a word-level reference model, plus directed scenarios.
module tb_stereo_pdm_deserializer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en_m = 1'b0;
   logic       en_s = 1'b0;
   logic       rdy_m = 1'b0;
   logic       rdy_s = 1'b0;
   logic       pdm_d = 1'b0;

   logic       pc_m, ls_m, ch_m, v_m, ov_m;
   logic       pc_s, ls_s, ch_s, v_s, ov_s;
   logic [7:0] d_m, d_s;

   int checks = 0;
   int errors = 0;

   int         mk [2];
   int         lcnt [2];
   int         rcnt [2];
   logic [7:0] lval [2];
   logic [7:0] rval [2];
   logic [8:0] fq [2][$];
   bit         mov [2];

   bit         dir = 1'b0;
   int         sel = 0;
   logic [7:0] lpat = 8'h00;
   logic [7:0] rpat = 8'h00;

   always #5 clk = ~clk;

   stereo_pdm_deserializer #(
      .WORD_LENGTH(8), .SYSTEM_FREQUENCY(8), .SAMPLING_FREQUENCY(1),
      .STEREO(0), .FIFO_DEPTH(4)
   ) dut_mono (
      .clock_i(clk), .reset_i(rst), .enable_i(en_m),
      .pdm_clk_o(pc_m), .pdm_data_i(pdm_d), .pdm_lrsel_o(ls_m),
      .data_o(d_m), .channel_o(ch_m), .valid_o(v_m),
      .ready_i(rdy_m), .overrun_o(ov_m)
   );

   stereo_pdm_deserializer #(
      .WORD_LENGTH(8), .SYSTEM_FREQUENCY(8), .SAMPLING_FREQUENCY(1),
      .STEREO(1), .FIFO_DEPTH(4)
   ) dut_st (
      .clock_i(clk), .reset_i(rst), .enable_i(en_s),
      .pdm_clk_o(pc_s), .pdm_data_i(pdm_d), .pdm_lrsel_o(ls_s),
      .data_o(d_s), .channel_o(ch_s), .valid_o(v_s),
      .ready_i(rdy_s), .overrun_o(ov_s)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         mk[m] = 0; lcnt[m] = 0; rcnt[m] = 0;
         lval[m] = 8'h00; rval[m] = 8'h00;
         fq[m].delete();
         mov[m] = 1'b0;
      end
   endtask

   // Period is 8 edges: rise on enabled edge 4 mod 8, fall on 0 mod 8.
   task automatic model_edge(input int m, input bit en, input bit rdy, input bit d);
      bit pop, push, full;
      logic [8:0] w;
      pop = (fq[m].size() > 0) && rdy;
      push = 1'b0;
      w = '0;
      if (!en) begin
         mk[m] = 0; lcnt[m] = 0; rcnt[m] = 0;
         lval[m] = 8'h00; rval[m] = 8'h00;
      end else begin
         mk[m]++;
         if (mk[m] % 8 == 4) begin
            lval[m] = {lval[m][6:0], d};
            lcnt[m]++;
            if (lcnt[m] == 8) begin
               push = 1'b1; w = {1'b0, lval[m]}; lcnt[m] = 0;
            end
         end else if (mk[m] % 8 == 0 && m == 1) begin
            rval[m] = {rval[m][6:0], d};
            rcnt[m]++;
            if (rcnt[m] == 8) begin
               push = 1'b1; w = {1'b1, rval[m]}; rcnt[m] = 0;
            end
         end
      end
      full = (fq[m].size() == 4);
      if (pop) void'(fq[m].pop_front());
      if (push) begin
         if (!full || pop) fq[m].push_back(w);
         else mov[m] = 1'b1;
      end
   endtask

   task automatic check_dut(input int m, input string p, input logic v,
                            input logic [7:0] d, input logic c, input logic ov,
                            input logic pc, input logic ls);
      logic [8:0] hd;
      bit ev;
      ev = (fq[m].size() > 0);
      hd = ev ? fq[m][0] : 9'h000;
      chk({p, "_valid"}, int'(v), int'(ev));
      chk({p, "_data"}, int'(d), int'(hd[7:0]));
      chk({p, "_chan"}, int'(c), int'(hd[8]));
      chk({p, "_overrun"}, int'(ov), int'(mov[m]));
      chk({p, "_pdmclk"}, int'(pc), int'(mk[m] % 8 >= 4));
      chk({p, "_lrsel"}, int'(ls), 0);
   endtask

   task automatic check_all();
      check_dut(0, "mono", v_m, d_m, ch_m, ov_m, pc_m, ls_m);
      check_dut(1, "st", v_s, d_s, ch_s, ov_s, pc_s, ls_s);
   endtask

   task automatic cycle();
      int kn;
      kn = ((sel == 1) ? en_s : en_m) ? mk[sel] + 1 : 1;
      if (dir && kn % 8 == 4) pdm_d = lpat[7 - lcnt[sel]];
      else if (dir && kn % 8 == 0) pdm_d = rpat[7 - rcnt[sel]];
      else pdm_d = 1'($urandom % 2);
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         model_edge(0, en_m, rdy_m, pdm_d);
         model_edge(1, en_s, rdy_s, pdm_d);
      end
      #1;
      check_all();
   endtask

   initial begin
      int nv, t0, t1, c0, c1, w0, w1;
      model_reset();
      repeat (2) cycle();
      #1 rst = 1'b0;
      cycle();

      // mono: 0xA5 on left, one word, valid for one cycle
      sel = 0; dir = 1'b1; lpat = 8'hA5; rpat = 8'h00;
      en_m = 1'b1; rdy_m = 1'b1;
      nv = 0; w0 = 0;
      repeat (70) begin
         cycle();
         if (v_m) begin nv++; w0 = int'(d_m); end
      end
      chk("mono_valid_cycles", nv, 1);
      chk("mono_word", w0, 'hA5);
      en_m = 1'b0; rdy_m = 1'b0;
      cycle();

      // stereo: 0x3C left then 0xC3 right four cycles later
      sel = 1; lpat = 8'h3C; rpat = 8'hC3;
      en_s = 1'b1; rdy_s = 1'b1;
      nv = 0; t0 = 0; t1 = 0; w0 = 0; w1 = 0; c0 = 0; c1 = 0;
      for (int i = 0; i < 72; i++) begin
         cycle();
         if (v_s) begin
            if (nv == 0) begin t0 = i; w0 = int'(d_s); c0 = int'(ch_s); end
            else if (nv == 1) begin t1 = i; w1 = int'(d_s); c1 = int'(ch_s); end
            nv++;
         end
      end
      chk("st_words", nv, 2);
      chk("st_left", w0, 'h3C);
      chk("st_left_ch", c0, 0);
      chk("st_right", w1, 'hC3);
      chk("st_right_ch", c1, 1);
      chk("st_gap", t1 - t0, 4);
      chk("st_no_overrun", int'(ov_s), 0);
      en_s = 1'b0; dir = 1'b0;
      cycle();

      // three frames with no sink: four kept, later words dropped
      en_s = 1'b1; rdy_s = 1'b0;
      repeat (200) cycle();
      chk("ovr_flag", int'(ov_s), 1);
      en_s = 1'b0; rdy_s = 1'b1;
      repeat (6) cycle();
      chk("ovr_drained", int'(v_s), 0);
      chk("ovr_sticky", int'(ov_s), 1);

      rst = 1'b1; cycle(); #1 rst = 1'b0;
      rdy_s = 1'b0;

      // full FIFO with pop on the right-word completion edge
      en_s = 1'b1;
      while (mk[1] < 192) begin
         rdy_s = (mk[1] + 1 == 131) || (mk[1] + 1 == 192);
         cycle();
      end
      rdy_s = 1'b0;
      chk("full_pop_overrun", int'(ov_s), 0);
      chk("full_pop_head", int'(d_s), int'(fq[1][0][7:0]));
      chk("full_pop_occ", fq[1].size(), 4);
      en_s = 1'b0; rdy_s = 1'b1;
      repeat (6) cycle();
      chk("full_pop_drained", int'(v_s), 0);

      // disable mid-word with one word queued, then re-enable with all ones
      en_s = 1'b1; rdy_s = 1'b0;
      while (mk[1] < 104) begin
         rdy_s = (mk[1] + 1 == 64);
         cycle();
      end
      en_s = 1'b0;
      cycle();
      chk("dis_pdmclk", int'(pc_s), 0);
      chk("dis_valid", int'(v_s), 1);
      rdy_s = 1'b1;
      cycle();
      chk("dis_popped", int'(v_s), 0);
      dir = 1'b1; lpat = 8'hFF; rpat = 8'hFF;
      en_s = 1'b1;
      nv = 0; w0 = 0;
      repeat (66) begin
         cycle();
         if (v_s && nv == 0) begin nv = 1; w0 = int'(d_s); end
      end
      chk("reen_word", w0, 'hFF);
      dir = 1'b0;

      // async reset between edges, mid-word with FIFO non-empty
      en_s = 1'b0; cycle();
      en_s = 1'b1; rdy_s = 1'b0;
      repeat (70) cycle();
      chk("rst_pre_valid", int'(v_s), 1);
      #1 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      chk("rst_async_valid", int'(v_s), 0);
      chk("rst_async_data", int'(d_s), 0);
      #2 rst = 1'b0;
      repeat (3) begin
         cycle();
         chk("rst_pre_rise", int'(pc_s), 0);
      end
      cycle();
      chk("rst_first_rise", int'(pc_s), 1);
      repeat (4) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stereo_pdm_deserializer.md
STEREO_PDM_DESERIALIZER -- requirements
Module: stereo_pdm_deserializer

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 16: bits per output word, range 2..32.
REQ-002 SHALL have parameter SYSTEM_FREQUENCY, default 100000000: clock_i frequency in Hz.
REQ-003 SHALL have parameter SAMPLING_FREQUENCY, default 1000000: pdm_clk_o frequency in Hz. HALF = SYSTEM_FREQUENCY/(2*SAMPLING_FREQUENCY) SHALL be >= 2.
REQ-004 SHALL have parameter STEREO, default 1: 1 captures left and right, 0 captures left only.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries, power of 2, >= 2.
REQ-006 SHALL have port clock_i, input, 1: single system clock, rising-edge.
REQ-007 SHALL have port reset_i, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port enable_i, input, 1: capture enable.
REQ-009 SHALL have port pdm_clk_o, output, 1: microphone clock.
REQ-010 SHALL have port pdm_data_i, input, 1: shared PDM data line.
REQ-011 SHALL have port pdm_lrsel_o, output, 1: microphone L/R select, constant 0.
REQ-012 SHALL have port data_o, output, WORD_LENGTH: FIFO head word.
REQ-013 SHALL have port channel_o, output, 1: FIFO head channel, 0 = left, 1 = right.
REQ-014 SHALL have port valid_o, output, 1: FIFO not empty.
REQ-015 SHALL have port ready_i, input, 1: sink accepts the head word.
REQ-016 SHALL have port overrun_o, output, 1: sticky flag, word dropped.

Function
REQ-017 Divider: a counter SHALL run 0..HALF-1 while enable_i = 1. pdm_clk_o SHALL toggle on the edge where the count equals HALF-1. Period = 2*HALF cycles, 50% duty.
REQ-018 Rise event = the edge that drives pdm_clk_o 0->1. Fall event = the edge that drives it 1->0.
REQ-019 The first rise event SHALL occur on the HALF-th enabled edge after enable_i goes high.
REQ-020 Left bit SHALL be sampled from pdm_data_i at each rise event. Right bit (STEREO=1 only) SHALL be sampled at each fall event.
REQ-021 Each channel shift register SHALL shift left with the new bit into the LSB. Word format: first sampled bit is the MSB.
REQ-022 Shared bit counter SHALL increment at each fall event and wrap from WORD_LENGTH-1 to 0.
REQ-023 Left word SHALL complete at the rise event of bit index WORD_LENGTH-1. Right word SHALL complete at the following fall event.
REQ-024 On completion edge, {channel, shift_register with the bit sampled at that edge} SHALL be pushed. valid_o SHALL be high after that same edge if the FIFO was empty (latency 0 cycles from the last sample edge).
REQ-025 Pop SHALL occur on an edge with valid_o && ready_i. data_o and channel_o SHALL show the head combinationally. Order SHALL be FIFO.
REQ-026 Push when full and no pop SHALL drop the new word, leave FIFO contents unchanged, and set overrun_o = 1.
REQ-027 Push and pop on the same edge when full SHALL both succeed. Occupancy is unchanged and overrun_o is not set.
REQ-028 Push and pop on the same edge when empty is impossible because valid_o = 0. Pop when empty SHALL be ignored.
REQ-029 Read and write pointers SHALL wrap modulo FIFO_DEPTH. Occupancy counter width = log2(FIFO_DEPTH)+1.
REQ-030 enable_i low SHALL take effect at the next edge: divider count 0, pdm_clk_o 0, bit counter 0, shift registers 0. Partial words are discarded. The FIFO keeps draining. overrun_o is retained.
REQ-031 enable_i re-assert SHALL restart per REQ-019 with no stale bits.
REQ-032 overrun_o SHALL clear only on reset_i.

Reset
REQ-033 reset_i high SHALL, asynchronously, set: pdm_clk_o = 0, valid_o = 0, data_o = 0, channel_o = 0, overrun_o = 0, all counters, shift registers and pointers = 0.
REQ-034 pdm_lrsel_o SHALL be 0 at all times.
REQ-035 Reset mid-word or mid-FIFO SHALL discard all contents. After release, operation SHALL follow REQ-019.

Verification
Bench parameters unless noted: WORD_LENGTH=8, SYSTEM_FREQUENCY=8, SAMPLING_FREQUENCY=1 (HALF=4), FIFO_DEPTH=4.
REQ-036 Mono (STEREO=0), ready_i=1, bits 1,0,1,0,0,1,0,1 at rise events -> one word data_o = 0xA5, channel_o = 0; valid_o high exactly 1 cycle, after the 8th rise event.
REQ-037 Stereo, left bits = 0x3C, right bits = 0xC3, ready_i=1 -> 0x3C/ch0, then 4 cycles later 0xC3/ch1; overrun_o stays 0.
REQ-038 Stereo, ready_i=0 for 3 frames -> first 4 words kept in order (L0,R0,L1,R1), 5th word dropped, overrun_o=1; drain yields the 4 words intact.
REQ-039 FIFO full, ready_i=1 on the right-word completion edge -> word accepted, occupancy stays 4, overrun_o=0.
REQ-040 enable_i low after 5 bits with FIFO holding 1 word -> pdm_clk_o=0 next cycle, FIFO word still poppable; re-enable with 0xFF -> output 0xFF, with no old bits mixed in.
REQ-041 reset_i pulsed between clock edges mid-word with FIFO non-empty -> all outputs 0 immediately, without waiting for an edge; first rise event occurs 4 edges after release.
